bin2bcd_hex8: RTL and testbench
===============================

Name: bin2bcd_hex8

Overview:
Sequential binary-to-BCD converter (shift-add-3, "double dabble") that feeds the 8-digit seven-segment scanner's Disp_data input.
- Takes an unsigned binary count from application logic (counters, timers, UART-received values).
- Produces 8 packed BCD nibbles, MS digit in [31:28], so the scanner displays the decimal value.
- Output register only changes on conversion completion, so the display never shows partial results.

Parameters:
BIN_W, 27, width of binary input; must be >= 27 (covers 99_999_999).
DIGITS, 8, number of BCD digits; Bcd width = 4*DIGITS.

Ports:
Clk  input  1  system clock (50 MHz board clock).
Reset  input  1  synchronous, active-high reset.
Start  input  1  conversion request; sampled only in IDLE.
Bin  input  BIN_W  unsigned binary value; captured on the accepting edge.
Busy  output  1  high while a conversion is in progress.
Done  output  1  one-cycle pulse; Bcd/Overflow updated in the same cycle.
Overflow  output  1  last result saturated (Bin > 10^DIGITS-1).
Bcd  output  4*DIGITS  packed BCD result; connects to scanner Disp_data.

Behaviour:
- Reset (synchronous, Reset=1 at rising edge):
  - State to IDLE.
  - Busy=0, Done=0, Overflow=0, Bcd=0.
  - Shift counter and working registers cleared.
- FSM states are IDLE and SHIFT.
- IDLE:
  - At a rising edge with Start=1, capture Bin into the shift register and clear the BCD working register.
  - Set the overflow-pending flag = (Bin > 10^DIGITS-1).
  - Counter=0, go to SHIFT, Busy=1 from the following cycle.
- SHIFT: each edge performs one iteration, all in a single cycle:
  - Each BCD working nibble >= 5 gets +3.
  - The {BCD, bin} register is then shifted left 1, with the MSB of bin entering BCD bit 0.
  - Counter increments.
- Final iteration (counter = BIN_W-1), at that same edge:
  - Bcd <= working result, or all nibbles = 4'h9 if overflow pending.
  - Overflow <= overflow pending; Done <= 1; Busy <= 0; state to IDLE.
- Latency: with the Start-accepting edge as edge N, Done is high in the cycle after edge N+BIN_W.
  - Default BIN_W=27: Done is high 27 cycles after acceptance.
- Done is high for exactly 1 cycle; otherwise 0.
- Bcd and Overflow hold their previous values throughout a conversion and change only with Done.
- Start while Busy=1: ignored, not queued.
  - Start held continuously restarts on the first IDLE edge, giving one conversion every BIN_W+1 cycles.
- Bin changes after acceptance: no effect on the running conversion.
- Reset mid-conversion:
  - Conversion aborted, no Done pulse.
  - All outputs return to reset values, including Bcd=0.
- Reset and Start at the same edge: reset wins.
- Add-3 correction uses the 4-bit nibble value only; no carry between nibbles before the shift.
- Working BCD register is exactly 4*DIGITS bits; bits shifted out of the top are discarded, which only happens in the overflow case.

Test Plan:
1. Reset held 10 cycles, then released -> Bcd=32'h0, Busy=0, Done=0, Overflow=0; no Done pulse without Start.
2. Bin=27'd12345678, Start pulsed 1 cycle -> Busy=1 the next cycle; Done pulse 27 cycles after the accepting edge; Bcd=32'h12345678, Overflow=0; Bcd unchanged (0) until Done.
3. Back-to-back conversions:
   - Bin=0 -> Bcd=32'h00000000.
   - Bin=27'd99_999_999 -> Bcd=32'h99999999, Overflow=0.
   - Bin=27'd100_000_000 -> Bcd=32'h99999999, Overflow=1.
   - Bin=27'd9 -> Bcd=32'h00000009, Overflow cleared to 0.
4. Start held high for 100 cycles with Bin=27'd4096 -> Done pulses exactly 28 cycles apart, each with Bcd=32'h00004096.
5. Start accepted with Bin=27'd555, then Start pulsed and Bin changed to 27'd777 at cycle 10 of conversion -> single Done, Bcd=32'h00000555; no second conversion.
6. Reset asserted at cycle 15 of a conversion of 27'd87654321 after a prior result of 32'h00000042 -> Done never pulses; Bcd=0 after reset; the next Start with 27'd87654321 yields 32'h87654321.

Source files
------------

// File: rtl/bin2bcd_hex8_if.sv
// Request/result bundle between application logic and the binary-to-BCD converter.
// The master drives the request (Start, Bin). The slave returns status and the packed BCD result.
interface bin2bcd_hex8_if #(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
);
   logic                  Start;
   logic [BIN_W-1:0]      Bin;
   logic                  Busy;
   logic                  Done;
   logic                  Overflow;
   logic [4*DIGITS-1:0]   Bcd;

   modport master (
      output Start, Bin,
      input  Busy, Done, Overflow, Bcd
   );

   modport slave (
      input  Start, Bin,
      output Busy, Done, Overflow, Bcd
   );
endinterface

// File: rtl/bin2bcd_hex8.sv
// Sequential shift-add-3 binary-to-BCD converter that feeds the seven-segment scanner.
// The Bcd and Overflow outputs change only at the Done pulse, so the display never
// shows a partially converted value.
//
// state | meaning
// IDLE  | waiting for Start; the last result is held on Bcd/Overflow
// SHIFT | one add-3/shift iteration per clock; BIN_W iterations in total
module bin2bcd_hex8 #(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   bin2bcd_hex8_if.slave bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam int EXT_W = (BIN_W > 64) ? BIN_W : 64;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   function automatic longint unsigned dec_max(input int n);
      longint unsigned v;
      v = 1;
      for (int i = 0; i < n; i++) v = v * 10;
      return v - 1;
   endfunction

   localparam longint unsigned BCD_MAX = dec_max(DIGITS);

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t               state, state_nxt;
   logic [BIN_W-1:0]     bin_sr;
   logic [BCD_W-1:0]     bcd_work;
   logic [CNT_W-1:0]     cnt;
   logic                 ovf_pend;
   logic                 done_q;
   logic                 ovf_q;
   logic [BCD_W-1:0]     bcd_q;

   logic                 load;
   logic                 step;
   logic                 last;
   logic                 over_max;
   logic [BCD_W-1:0]     bcd_adj;
   logic [BCD_W-1:0]     bcd_shift;
   logic [BIN_W-1:0]     bin_shift;
   logic [3:0]           nib;
   logic [EXT_W-1:0]     bin_ext;

   // Values above the largest displayable decimal saturate to all nines.
   assign bin_ext  = EXT_W'(bus.Bin);
   assign over_max = (bin_ext > EXT_W'(BCD_MAX));

   assign bus.Busy     = (state == SHIFT);
   assign bus.Done     = done_q;
   assign bus.Overflow = ovf_q;
   assign bus.Bcd      = bcd_q;

   // One iteration: correct each nibble independently, then shift {BCD, bin} left by one.
   always_comb begin
      bcd_adj = '0;
      nib     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         nib = bcd_work[4*i +: 4];
         bcd_adj[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
      {bcd_shift, bin_shift} = {bcd_adj, bin_sr} << 1;
   end

   // Next-state and control decode.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Working registers and the result outputs, which update only on the final iteration.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bin_sr   <= '0;
         bcd_work <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         bcd_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            bin_sr   <= bus.Bin;
            bcd_work <= '0;
            cnt      <= '0;
            ovf_pend <= over_max;
         end
         if (step) begin
            bin_sr   <= bin_shift;
            bcd_work <= bcd_shift;
            cnt      <= cnt + CNT_W'(1);
         end
         if (last) begin
            bcd_q  <= ovf_pend ? {DIGITS{4'h9}} : bcd_shift;
            ovf_q  <= ovf_pend;
            done_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bin2bcd_hex8.sv
// Self-checking bench for bin2bcd_hex8: directed scenarios plus random values,
// with expected results derived from decimal arithmetic.
module tb_bin2bcd_hex8;
   localparam int BIN_W  = 27;
   localparam int DIGITS = 8;
   localparam int LAT    = BIN_W;

   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   bin2bcd_hex8_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin2bcd_hex8 #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_bcd(input longint unsigned v);
      logic [31:0] r;
      r = '0;
      if (v > 64'd99_999_999) return 32'h9999_9999;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input longint unsigned v);
      return (v > 64'd99_999_999);
   endfunction

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Full conversion: checks Busy, latency, held output, result and the single-cycle Done.
   task automatic run_conv(input longint unsigned v, input string tag);
      logic [31:0] bcd_before;
      int lat;
      bit held;
      bcd_before = bus.Bcd;
      held = 1'b1;
      lat = -1;
      bus.Bin   = BIN_W'(v);
      bus.Start = 1'b1;
      tick;
      bus.Start = 1'b0;
      check_val({tag, "_busy"}, 64'(bus.Busy), 64'd1);
      for (int i = 1; i <= LAT + 10; i++) begin
         tick;
         if (bus.Done) begin
            lat = i;
            break;
         end
         if (bus.Bcd !== bcd_before) held = 1'b0;
      end
      check_val({tag, "_latency"}, 64'(lat), 64'(LAT));
      check_val({tag, "_held"}, 64'(held), 64'd1);
      check_val({tag, "_bcd"}, 64'(bus.Bcd), 64'(ref_bcd(v)));
      check_val({tag, "_ovf"}, 64'(bus.Overflow), 64'(ref_ovf(v)));
      tick;
      check_val({tag, "_done_1cyc"}, 64'(bus.Done), 64'd0);
      check_val({tag, "_idle"}, 64'(bus.Busy), 64'd0);
   endtask

   initial begin
      int n_done;
      int prev_t;
      int lat;
      longint unsigned v;

      Reset     = 1'b1;
      bus.Start = 1'b0;
      bus.Bin   = '0;

      // Reset held 10 cycles.
      repeat (10) tick;
      Reset = 1'b0;
      tick;
      check_val("rst_bcd",  64'(bus.Bcd), 64'd0);
      check_val("rst_busy", 64'(bus.Busy), 64'd0);
      check_val("rst_done", 64'(bus.Done), 64'd0);
      check_val("rst_ovf",  64'(bus.Overflow), 64'd0);
      n_done = 0;
      repeat (10) begin
         tick;
         if (bus.Done) n_done++;
      end
      check_val("no_spurious_done", 64'(n_done), 64'd0);

      // Basic conversion and back-to-back boundary values.
      run_conv(64'd12_345_678, "conv_12345678");
      run_conv(64'd0, "conv_zero");
      run_conv(64'd99_999_999, "conv_max");
      run_conv(64'd100_000_000, "conv_ovf");
      run_conv(64'd9, "conv_nine");

      // Start held continuously.
      bus.Bin   = BIN_W'(4096);
      bus.Start = 1'b1;
      n_done = 0;
      prev_t = -1;
      for (int t = 1; t <= 100; t++) begin
         tick;
         if (bus.Done) begin
            n_done++;
            if (prev_t >= 0) check_val("held_gap", 64'(t - prev_t), 64'(LAT + 1));
            check_val("held_bcd", 64'(bus.Bcd), 64'(ref_bcd(64'd4096)));
            prev_t = t;
         end
      end
      bus.Start = 1'b0;
      check_val("held_count", 64'(n_done), 64'd3);
      for (int i = 0; i < LAT + 10 && bus.Busy; i++) tick;
      check_val("held_drain", 64'(bus.Busy), 64'd0);
      tick;

      // Start and Bin changes during a conversion are ignored.
      bus.Bin   = BIN_W'(555);
      bus.Start = 1'b1;
      tick;
      bus.Start = 1'b0;
      repeat (9) tick;
      bus.Bin   = BIN_W'(777);
      bus.Start = 1'b1;
      tick;
      bus.Start = 1'b0;
      lat = -1;
      for (int i = 11; i <= LAT + 10; i++) begin
         tick;
         if (bus.Done) begin
            lat = i;
            break;
         end
      end
      check_val("ignore_latency", 64'(lat), 64'(LAT));
      check_val("ignore_bcd", 64'(bus.Bcd), 64'(ref_bcd(64'd555)));
      n_done = 0;
      repeat (LAT + 10) begin
         tick;
         if (bus.Done) n_done++;
      end
      check_val("ignore_no_second", 64'(n_done), 64'd0);
      check_val("ignore_idle", 64'(bus.Busy), 64'd0);

      // Reset mid-conversion.
      run_conv(64'd42, "conv_42");
      bus.Bin   = BIN_W'(87_654_321);
      bus.Start = 1'b1;
      tick;
      bus.Start = 1'b0;
      n_done = 0;
      repeat (14) begin
         tick;
         if (bus.Done) n_done++;
      end
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      check_val("abort_bcd",  64'(bus.Bcd), 64'd0);
      check_val("abort_busy", 64'(bus.Busy), 64'd0);
      check_val("abort_ovf",  64'(bus.Overflow), 64'd0);
      repeat (LAT + 10) begin
         tick;
         if (bus.Done) n_done++;
      end
      check_val("abort_no_done", 64'(n_done), 64'd0);
      run_conv(64'd87_654_321, "conv_after_abort");

      // Reset and Start at the same edge: reset wins.
      run_conv(64'd100_000_001, "conv_ovf2");
      Reset     = 1'b1;
      bus.Start = 1'b1;
      bus.Bin   = BIN_W'(5);
      tick;
      Reset     = 1'b0;
      bus.Start = 1'b0;
      check_val("rst_start_busy", 64'(bus.Busy), 64'd0);
      check_val("rst_start_ovf",  64'(bus.Overflow), 64'd0);
      tick;
      check_val("rst_start_busy2", 64'(bus.Busy), 64'd0);

      // Random values, including a band around the saturation threshold.
      for (int k = 0; k < 30; k++) begin
         if (k % 3 == 0) v = 64'(99_999_990 + $urandom_range(0, 20));
         else            v = 64'($urandom_range(0, (1 << BIN_W) - 1));
         run_conv(v, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
